// File: rtl/laser_tx_serializer_if.sv
// laser_tx_serializer_if: byte-queue read port between the 64-entry TX queue
// and the laser serializer.
//
// Handshake: q_empty=0 means q_data holds a valid head byte (valid); q_read is
// a single-cycle pop strobe (ready). A byte transfers on a rising clock edge
// where q_empty=0 and q_read=1. The queue advances on that same edge, and q_read
// is never raised while q_empty=1.
interface laser_tx_serializer_if;
  logic [7:0] q_data;
  logic       q_empty;
  logic       q_read;

  // Serializer side: consumes the head byte and pops the queue.
  modport master (input q_data, input q_empty, output q_read);
  // Queue side: presents the head byte and empty flag, and receives the pop.
  modport slave  (output q_data, output q_empty, input q_read);
endinterface

// File: rtl/laser_tx_serializer.sv
// laser_tx_serializer: pops bytes from the TX queue and frames each one as
// start(1), 8 data bits LSB-first, optional even parity, and stop(0). Every bit
// is held for CLKS_PER_BIT clocks on a registered laser_out. Frames run back to
// back with no gap while the queue stays non-empty.
// Optional feature macro: PARITY_EN. Defining it adds the even-parity bit.
module laser_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tx_en,
  laser_tx_serializer_if.master        q_if,
  output logic                         laser_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic [2:0]                   dbg_state_o
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             laser_q, laser_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_end;
  logic go;

  assign bit_end = (div_q == DIV_LAST);
  // Reset is included so that no pop can happen while the block is held in reset.
  assign go      = tx_en & ~q_if.q_empty & ~reset;

  // Register the state, counters, data shifter and laser drive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      laser_q  <= 1'b0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      laser_q  <= laser_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic, counter and shifter updates, pop strobe, and frame_done.
  always_comb begin
    state_d     = state_q;
    div_d       = bit_end ? '0 : div_q + DIV_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    q_if.q_read = 1'b0;
    frame_done  = 1'b0;
`ifdef PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (go) begin
          q_if.q_read = 1'b1;
          shift_d     = q_if.q_data;
          bit_d       = '0;
          state_d     = START;
`ifdef PARITY_EN
          parity_d    = ^q_if.q_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          if (go) begin
            // Reload straight into the next start bit, so there is no idle gap.
            q_if.q_read = 1'b1;
            shift_d     = q_if.q_data;
            bit_d       = '0;
            state_d     = START;
`ifdef PARITY_EN
            parity_d    = ^q_if.q_data;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Compute the laser level for the cycle being entered, so the output is
  // registered and stays steady for a whole bit period.
  always_comb begin
    laser_d = 1'b0;
    case (state_d)
      START:   laser_d = 1'b1;
      DATA:    laser_d = shift_d[0];
`ifdef PARITY_EN
      PARITY:  laser_d = parity_d;
`endif
      default: laser_d = 1'b0;
    endcase
  end

  assign laser_out   = laser_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_laser_tx_serializer.sv
// tb_laser_tx_serializer: directed tests for laser_tx_serializer with
// CLKS_PER_BIT=4. Inputs change on the falling edge. Outputs are sampled 1ns
// after the falling edge. The source byte queue pops when q_read is seen high.
module tb_laser_tx_serializer;

  localparam int K = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * K;

  // Clock and reset
  logic clock = 1'b0;
  logic reset;
  logic tx_en;
  logic laser_out, busy, frame_done;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  laser_tx_serializer_if ifc ();

  laser_tx_serializer #(.CLKS_PER_BIT(K)) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_en       (tx_en),
    .q_if        (ifc.master),
    .laser_out   (laser_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // Source queue and captured traces
  logic [7:0] src_q[$];
  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic lo_a[0:127];
  logic bz_a[0:127];
  logic rd_a[0:127];
  logic fd_a[0:127];

  // Driver tasks
  task automatic refresh();
    ifc.q_empty = (src_q.size() == 0);
    ifc.q_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src_q.push_back(b);
    refresh();
  endtask

  // Called just after sampling. Applies the pop at the next rising edge, then
  // returns at the following falling edge.
  task automatic advance();
    logic rd;
    logic [7:0] tmp;
    rd = ifc.q_read;
    @(posedge clock);
    #1;
    if (rd) begin
      tmp = src_q.pop_front();
      pops++;
    end
    refresh();
    @(negedge clock);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      lo_a[i] = laser_out;
      bz_a[i] = busy;
      rd_a[i] = ifc.q_read;
      fd_a[i] = frame_done;
      advance();
    end
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    tx_en = 1'b0;
    refresh();
    @(negedge clock);
    #1;
    checks++;
    if (laser_out !== 1'b0 || busy !== 1'b0 || ifc.q_read !== 1'b0 ||
        frame_done !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: laser=%b busy=%b rd=%b fd=%b st=%0d, need all 0",
               laser_out, busy, ifc.q_read, frame_done, dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_byte();
    // 0xA5: bit periods 1,1,0,1,0,0,1,0,1,(parity 0),0
    logic [10:0] pat;
    pat = 11'h14B;
    pops = 0;
    tx_en = 1'b1;
    push(8'hA5);
    capture(FL + 4);
    checks++;
    if (rd_a[0] !== 1'b1 || bz_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: rd=%b busy=%b, need rd=1 busy=0", rd_a[0], bz_a[0]);
    end
    for (int i = 1; i <= FL; i++) begin
      checks++;
      if (lo_a[i] !== pat[(i-1)/K] || bz_a[i] !== 1'b1 || fd_a[i] !== (i == FL)) begin
        errors++;
        $display("FAIL single_frame cyc %0d: laser=%b busy=%b fd=%b, need laser=%b busy=1 fd=%b",
                 i, lo_a[i], bz_a[i], fd_a[i], pat[(i-1)/K], (i == FL));
      end
    end
    checks++;
    if (bz_a[FL+1] !== 1'b0 || lo_a[FL+1] !== 1'b0 || pops !== 1) begin
      errors++;
      $display("FAIL single_idle: busy=%b laser=%b pops=%0d, need 0 0 1",
               bz_a[FL+1], lo_a[FL+1], pops);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] pat1, pat2;
    pat1 = 11'h001;  // 0x00
    pat2 = 11'h1FF;  // 0xFF, even parity 0
    pops = 0;
    tx_en = 1'b1;
    src_q.push_back(8'h00);
    push(8'hFF);
    capture(2*FL + 3);
    checks++;
    if (rd_a[FL] !== 1'b1 || fd_a[FL] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload: rd=%b fd=%b at last stop cycle, need 1 1", rd_a[FL], fd_a[FL]);
    end
    for (int i = 1; i <= 2*FL; i++) begin
      logic e;
      e = (i <= FL) ? pat1[(i-1)/K] : pat2[(i-1-FL)/K];
      checks++;
      if (lo_a[i] !== e || bz_a[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame cyc %0d: laser=%b busy=%b, need laser=%b busy=1",
                 i, lo_a[i], bz_a[i], e);
      end
    end
    checks++;
    if (bz_a[2*FL+1] !== 1'b0 || pops !== 2) begin
      errors++;
      $display("FAIL b2b_end: busy=%b pops=%0d, need 0 2", bz_a[2*FL+1], pops);
    end
  endtask

  task automatic test_tx_en();
    int fd_cnt;
    int fd_at;
    pops = 0;
    tx_en = 1'b0;
    src_q.push_back(8'h3C);
    push(8'h81);
    capture(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_a[i] !== 1'b0 || lo_a[i] !== 1'b0 || bz_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL txen_off cyc %0d: rd=%b laser=%b busy=%b, need 0 0 0",
                 i, rd_a[i], lo_a[i], bz_a[i]);
      end
    end
    tx_en  = 1'b1;
    fd_cnt = 0;
    fd_at  = -1;
    for (int c = 0; c < FL + 10; c++) begin
      if (c == 12) tx_en = 1'b0;
      #1;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_at = c;
      end
      bz_a[c] = busy;
      advance();
    end
    checks++;
    if (pops !== 1 || fd_cnt !== 1 || fd_at !== FL || bz_a[FL+1] !== 1'b0) begin
      errors++;
      $display("FAIL txen_drop: pops=%0d fd_cnt=%0d fd_at=%0d busy_after=%b, need 1 1 %0d 0",
               pops, fd_cnt, fd_at, bz_a[FL+1], FL);
    end
    checks++;
    if (src_q.size() !== 1) begin
      errors++;
      $display("FAIL txen_left: queue size=%0d, need 1", src_q.size());
    end
    src_q.delete();
    refresh();
  endtask

  task automatic test_empty();
    tx_en = 1'b1;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rd_a[i] !== 1'b0 || lo_a[i] !== 1'b0 || bz_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL empty cyc %0d: rd=%b laser=%b busy=%b, need 0 0 0",
                 i, rd_a[i], lo_a[i], bz_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    // 0x5A: bit periods 1,0,1,0,1,1,0,1,0,(parity 0),0
    logic [10:0] pat;
    pat = 11'h0B5;
    pops = 0;
    tx_en = 1'b1;
    push(8'hA5);
    capture(12);
    #1;
    checks++;
    if (dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL rst_mid_state: state=%0d, need 2 (DATA)", dbg_state);
    end
    reset = 1'b1;
    push(8'h5A);
    #1;
    checks++;
    if (laser_out !== 1'b0 || busy !== 1'b0 || ifc.q_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: laser=%b busy=%b rd=%b, need 0 0 0",
               laser_out, busy, ifc.q_read);
    end
    capture(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_a[i] !== 1'b0 || bz_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_hold cyc %0d: rd=%b busy=%b, need 0 0", i, rd_a[i], bz_a[i]);
      end
    end
    reset = 1'b0;
    capture(FL + 3);
    checks++;
    if (rd_a[0] !== 1'b1 || pops !== 2) begin
      errors++;
      $display("FAIL rst_repop: rd=%b pops=%0d, need 1 2", rd_a[0], pops);
    end
    for (int i = 1; i <= FL; i++) begin
      checks++;
      if (lo_a[i] !== pat[(i-1)/K]) begin
        errors++;
        $display("FAIL rst_frame cyc %0d: laser=%b, need %b", i, lo_a[i], pat[(i-1)/K]);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    // 0x07: 1,1,1,1,0,0,0,0,0,parity 1,stop 0
    logic [10:0] pat;
    pat = 11'h20F;
    tx_en = 1'b1;
    push(8'h07);
    capture(FL + 3);
    for (int i = 1; i <= FL; i++) begin
      checks++;
      if (lo_a[i] !== pat[(i-1)/K] || fd_a[i] !== (i == 44)) begin
        errors++;
        $display("FAIL parity cyc %0d: laser=%b fd=%b, need laser=%b fd=%b",
                 i, lo_a[i], fd_a[i], pat[(i-1)/K], (i == 44));
      end
    end
  endtask
`endif

  // Sequence and final report
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_tx_en();
    test_empty();
    test_reset_mid_data();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
